// File: rtl/single_mips_ctrl_pkg.sv
// Shared encodings for the single-cycle MIPS control sequencer:
// opcode/funct values, ALU_CTRL codes, FSM states and the decode bundle.
package single_mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        HALT
    } state_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src;
        logic [2:0] alu_ctrl;
        logic       branch;
        logic       jump;
        logic       is_mem;
        logic       is_store;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/single_mips_main_decoder.sv
// Pure combinational instruction decoder: opcode/funct -> select lines.
// Ports: op, funct in; dec (select lines + is_mem/is_store/illegal) out.
module single_mips_main_decoder
    import single_mips_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec          = '0;
        dec.alu_ctrl = ALU_ADD;
        unique case (1'b1)
            (op == OP_RTYPE): begin
                dec.reg_write = 1'b1;
                dec.reg_dst   = 1'b1;
                case (funct)
                    FN_ADD:  dec.alu_ctrl = ALU_ADD;
                    FN_SUB:  dec.alu_ctrl = ALU_SUB;
                    FN_AND:  dec.alu_ctrl = ALU_AND;
                    FN_OR:   dec.alu_ctrl = ALU_OR;
                    FN_SLT:  dec.alu_ctrl = ALU_SLT;
                    default: dec.illegal  = 1'b1;
                endcase
            end
            (op == OP_LW): begin
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src    = 1'b1;
                dec.is_mem     = 1'b1;
            end
            (op == OP_SW): begin
                dec.alu_src  = 1'b1;
                dec.is_mem   = 1'b1;
                dec.is_store = 1'b1;
            end
            (op == OP_BEQ): begin
                dec.alu_ctrl = ALU_SUB;
                dec.branch   = 1'b1;
            end
            (op == OP_ADDI): begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            (op == OP_J): begin
                dec.jump = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        // An undecodable word must not leak any partial decode.
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/single_mips_ctrl_sequencer.sv
// Control sequencer: decode, data-memory wait states, halt, retire count.
// Ports: CLK/RST, ins_mem_RD, Zero_Flag, DMEM_READY in; datapath selects,
// enables, DMEM_REQ/WE, HALTED/ILLEGAL_OP/BUS_ERR, RETIRED_CNT out.
// Optional MIPS_CTRL_TIMEOUT_EN: bus-error halt after TIMEOUT_CYCLES waits.
module single_mips_ctrl_sequencer
    import single_mips_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] ins_mem_RD,
    input  logic                  Zero_Flag,
    input  logic                  DMEM_READY,
    output logic                  PC_EN,
    output logic                  REG_FILE_WR_EN,
    output logic                  REG_FILE_WD3_SEL,
    output logic                  REG_FILE_A3_SEL,
    output logic                  ALU_SRC_B_SEL,
    output logic [2:0]            ALU_CTRL,
    output logic                  PC_SRC_SEL,
    output logic                  JUMP,
    output logic                  DMEM_REQ,
    output logic                  DMEM_WE,
    output logic                  HALTED,
    output logic                  ILLEGAL_OP,
    output logic                  BUS_ERR,
    output logic [CNT_WIDTH-1:0]  RETIRED_CNT
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("DATA_WIDTH must be 32");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t state;
    dec_t   dec;
    logic   run_st;
    logic   wait_st;
    logic   unused_instr;

    assign unused_instr = ^ins_mem_RD[25:6];

    single_mips_main_decoder u_dec (
        .op    (ins_mem_RD[31:26]),
        .funct (ins_mem_RD[5:0]),
        .dec   (dec)
    );

    assign run_st  = (state == RUN);
    assign wait_st = (state == MEM_WAIT);

    // Reset forces every enable low in the same cycle, even mid-access.
    always_comb begin
        DMEM_REQ = !RST && ((run_st && dec.is_mem) || wait_st);
        PC_EN    = !RST && ((run_st && !dec.illegal &&
                             (!dec.is_mem || DMEM_READY)) ||
                            (wait_st && DMEM_READY));
    end

    assign REG_FILE_WR_EN   = PC_EN && dec.reg_write;
    assign DMEM_WE          = DMEM_REQ && dec.is_store;
    assign REG_FILE_WD3_SEL = dec.mem_to_reg;
    assign REG_FILE_A3_SEL  = dec.reg_dst;
    assign ALU_SRC_B_SEL    = dec.alu_src;
    assign ALU_CTRL         = dec.alu_ctrl;
    assign PC_SRC_SEL       = dec.branch && Zero_Flag;
    assign JUMP             = dec.jump;

`ifdef MIPS_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] wait_cnt;
    logic          bus_err_q;

    assign BUS_ERR = bus_err_q;
`else
    assign BUS_ERR = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= RUN;
            HALTED      <= 1'b0;
            ILLEGAL_OP  <= 1'b0;
            RETIRED_CNT <= '0;
`ifdef MIPS_CTRL_TIMEOUT_EN
            wait_cnt    <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            if (PC_EN) begin
                RETIRED_CNT <= RETIRED_CNT + CNT_WIDTH'(1);
            end
            case (state)
                RUN: begin
                    if (dec.illegal) begin
                        state      <= HALT;
                        HALTED     <= 1'b1;
                        ILLEGAL_OP <= 1'b1;
                    end else if (dec.is_mem && !DMEM_READY) begin
                        state <= MEM_WAIT;
`ifdef MIPS_CTRL_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                MEM_WAIT: begin
                    if (DMEM_READY) begin
                        state <= RUN;
                    end
`ifdef MIPS_CTRL_TIMEOUT_EN
                    // READY on the limit cycle takes the branch above.
                    else if (wait_cnt == WAIT_LAST) begin
                        state     <= HALT;
                        HALTED    <= 1'b1;
                        bus_err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
`endif
                end
                default: state <= HALT;
            endcase
        end
    end

endmodule
